// File: rtl/change_logger.sv
// -----------------------------------------------------------------------------
// change_logger
//   Watches a sampled data word and records every value change as a
//   {delta-time, value, keepalive} entry in an internal show-ahead FIFO.
//   A downstream reader drains entries over a valid/ready port, for example
//   to serialise them into a VCD-style change dump. Intended to sit beside
//   a DUT with sample_in tied to the DUT data output.
//
//   Handshake: an entry transfers on a rising clock edge where out_valid and
//   out_ready are both 1. out_valid never depends on out_ready. Head fields
//   are held stable while out_valid=1 and out_ready=0. out_ready is ignored
//   while out_valid=0.
//
// Parameters
//   WIDTH   width of the sampled word and out_value
//   TIME_W  width of the delta counter and out_delta (saturates at 2**TIME_W-1)
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   clock          rising-edge clock, sole clock domain
//   reset          synchronous, active-high
//   sample_in      word under observation, sampled every cycle
//   out_valid      FIFO head entry valid
//   out_ready      reader accepts the head entry
//   out_value      value of the head entry
//   out_delta      cycles since the previous entry (first entry after reset: 0)
//   out_keepalive  head entry is a keepalive (counter saturated), not a change
//   count          entries currently stored, 0..DEPTH
//   overflow       sticky: an entry was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module change_logger #(
   parameter int WIDTH  = 8,
   parameter int TIME_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         sample_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_value,
   output logic [TIME_W-1:0]        out_delta,
   output logic                     out_keepalive,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [TIME_W-1:0] CTR_MAX  = '1;
   localparam logic [TIME_W-1:0] CTR_ONE  = TIME_W'(1);
   localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   typedef struct packed {
      logic              ka;
      logic [TIME_W-1:0] delta;
      logic [WIDTH-1:0]  value;
   } entry_t;

   // Input stage and change detector state
   logic [WIDTH-1:0]  s_q;
   logic              s_vld_q;   // s_q holds a real sample taken after reset
   logic [WIDTH-1:0]  last_q, last_d;
   logic [TIME_W-1:0] ctr_q, ctr_d;
   state_t            state_q, state_d;

   // FIFO state
   entry_t            mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              push;
   entry_t            push_entry;
   logic              pop;
   logic              full;
   logic              wr_en;
   entry_t            head;

   // Change detector: decides whether this cycle produces an entry
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      ctr_d      = ctr_q;
      push       = 1'b0;
      push_entry = '0;
      case (state_q)
         ST_FIRST: begin
            if (s_vld_q) begin
               push       = 1'b1;
               push_entry = '{ka: 1'b0, delta: '0, value: s_q};
               last_d     = s_q;
               ctr_d      = CTR_ONE;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (s_q != last_q) begin
               push       = 1'b1;
               push_entry = '{ka: 1'b0, delta: ctr_q, value: s_q};
               last_d     = s_q;
               ctr_d      = CTR_ONE;
            end else if (ctr_q == CTR_MAX) begin
               // Saturated: emit a keepalive so the dump never loses time
               push       = 1'b1;
               push_entry = '{ka: 1'b1, delta: ctr_q, value: last_q};
               ctr_d      = CTR_ONE;
            end else begin
               ctr_d = ctr_q + CTR_ONE;
            end
         end
         default: state_d = ST_FIRST;
      endcase
   end

   // FIFO control. A full FIFO still accepts a push when the head is popped
   // in the same cycle; otherwise the entry is dropped and overflow latches.
   always_comb begin
      pop        = out_valid && out_ready;
      full       = (count_q == FULL_CNT);
      wr_en      = push && (!full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q || (push && full && !pop);
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s_q        <= '0;
         s_vld_q    <= 1'b0;
         last_q     <= '0;
         ctr_q      <= '0;
         state_q    <= ST_FIRST;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         s_q        <= sample_in;
         s_vld_q    <= 1'b1;
         last_q     <= last_d;
         ctr_q      <= ctr_d;
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: only slots between rd_ptr and wr_ptr are visible
   always_ff @(posedge clock) begin
      if (!reset && wr_en) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // Show-ahead head, forced to zero while the FIFO is empty
   always_comb begin
      head          = mem_q[rd_ptr_q];
      out_valid     = (count_q != '0);
      out_value     = out_valid ? head.value : '0;
      out_delta     = out_valid ? head.delta : '0;
      out_keepalive = out_valid ? head.ka    : 1'b0;
      count         = count_q;
      overflow      = overflow_q;
   end

endmodule

// File: tb/tb_change_logger.sv
// -----------------------------------------------------------------------------
// tb_change_logger
//   Bench for change_logger built with TIME_W=4 and DEPTH=4 so that counter
//   saturation and FIFO-full behaviour are reached in few cycles. Expected
//   entries {ka, delta, value} are queued by each scenario before its stimulus
//   and compared in order as the reader accepts them.
// -----------------------------------------------------------------------------
module tb_change_logger;

   localparam int WIDTH  = 8;
   localparam int TIME_W = 4;
   localparam int DEPTH  = 4;
   localparam int EW     = 1 + TIME_W + WIDTH;

   logic              clock = 1'b0;
   logic              reset;
   logic [WIDTH-1:0]  sample_in;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_value;
   logic [TIME_W-1:0] out_delta;
   logic              out_keepalive;
   logic [2:0]        count;
   logic              overflow;

   int                n_checks = 0;
   int                n_fail   = 0;
   logic [EW-1:0]     exp_q[$];
   string             cur_test;
   logic              seen_valid;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   change_logger #(
      .WIDTH  (WIDTH),
      .TIME_W (TIME_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .sample_in     (sample_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_value     (out_value),
      .out_delta     (out_delta),
      .out_keepalive (out_keepalive),
      .count         (count),
      .overflow      (overflow)
   );

   // ---------------- driver / scoreboard ----------------
   // One clock cycle: apply inputs, observe at the falling edge, let the
   // rising edge commit, return 1 time unit after it.
   task automatic step(input logic [WIDTH-1:0] s, input logic rdy);
      logic [EW-1:0] act_e;
      logic [EW-1:0] exp_e;
      sample_in = s;
      out_ready = rdy;
      @(negedge clock);
      seen_valid = out_valid;
      if (out_valid && out_ready) begin
         act_e = {out_keepalive, out_delta, out_value};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_entry: got ka=%0b delta=%0d value=%0d, expected no entry",
                     cur_test, act_e[EW-1], act_e[EW-2:WIDTH], act_e[WIDTH-1:0]);
         end else begin
            exp_e = exp_q.pop_front();
            if (act_e !== exp_e) begin
               n_fail++;
               $display("FAIL %s entry: got ka=%0b delta=%0d value=%0d, expected ka=%0b delta=%0d value=%0d",
                        cur_test, act_e[EW-1], act_e[EW-2:WIDTH], act_e[WIDTH-1:0],
                        exp_e[EW-1], exp_e[EW-2:WIDTH], exp_e[WIDTH-1:0]);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step('0, 1'b0);
      step('0, 1'b0);
      reset = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [EW-1:0] ent(input logic ka, input int d, input int v);
      return {ka, TIME_W'(d), WIDTH'(v)};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      cur_test = "reset";
      reset = 1'b1;
      step(8'hAA, 1'b1);
      step(8'hAA, 1'b1);
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset out_valid: got %0b, expected 0", out_valid); end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL reset count: got %0d, expected 0", count); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset overflow: got %0b, expected 0", overflow); end
      n_checks++; if (out_value !== 8'd0)   begin n_fail++; $display("FAIL reset out_value: got %0d, expected 0", out_value); end
      n_checks++; if (out_delta !== 4'd0)   begin n_fail++; $display("FAIL reset out_delta: got %0d, expected 0", out_delta); end
      n_checks++; if (out_keepalive !== 1'b0) begin n_fail++; $display("FAIL reset out_keepalive: got %0b, expected 0", out_keepalive); end
      reset = 1'b0;
   endtask

   task automatic test_single_value();
      int first_v;
      cur_test = "single_value";
      do_reset();
      exp_q.push_back(ent(1'b0, 0, 32));
      first_v = 0;
      for (int i = 1; i <= 10; i++) begin
         step(8'd32, 1'b1);
         if (seen_valid && first_v == 0) first_v = i;
      end
      n_checks++; if (first_v !== 3)        begin n_fail++; $display("FAIL single_value first_valid_cycle: got %0d, expected 3", first_v); end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL single_value count: got %0d, expected 0", count); end
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL single_value pending: got %0d left, expected 0", exp_q.size()); end
   endtask

   task automatic test_sequence();
      int vals[6] = '{32, 28, 109, 111, 1, 74};
      int lens[6] = '{1, 5, 1, 8, 3, 6};
      int dels[6] = '{0, 1, 5, 1, 8, 3};
      cur_test = "sequence";
      do_reset();
      for (int k = 0; k < 6; k++) exp_q.push_back(ent(1'b0, dels[k], vals[k]));
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < lens[k]; j++) step(WIDTH'(vals[k]), 1'b1);
      end
      step(8'd74, 1'b1);
      step(8'd74, 1'b1);
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL sequence pending: got %0d left, expected 0", exp_q.size()); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL sequence overflow: got %0b, expected 0", overflow); end
   endtask

   task automatic test_keepalive();
      cur_test = "keepalive";
      do_reset();
      exp_q.push_back(ent(1'b0, 0, 5));
      exp_q.push_back(ent(1'b1, 15, 5));
      exp_q.push_back(ent(1'b1, 15, 5));
      exp_q.push_back(ent(1'b0, 10, 9));
      for (int i = 0; i < 40; i++) step(8'd5, 1'b1);
      for (int i = 0; i < 6; i++)  step(8'd9, 1'b1);
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL keepalive pending: got %0d left, expected 0", exp_q.size()); end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL keepalive count: got %0d, expected 0", count); end
   endtask

   task automatic test_overflow();
      logic [EW-1:0] head0;
      logic [EW-1:0] head1;
      cur_test = "overflow";
      do_reset();
      for (int i = 0; i < 8; i++) step(WIDTH'(i % 2), 1'b0);
      head0 = {out_keepalive, out_delta, out_value};
      n_checks++; if (count !== 3'd4)       begin n_fail++; $display("FAIL overflow count_full: got %0d, expected 4", count); end
      n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL overflow flag: got %0b, expected 1", overflow); end
      n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL overflow out_valid: got %0b, expected 1", out_valid); end
      n_checks++; if (head0 !== ent(1'b0, 0, 0)) begin n_fail++; $display("FAIL overflow head: got %0h, expected %0h", head0, ent(1'b0, 0, 0)); end
      for (int i = 0; i < 3; i++) step(8'd1, 1'b0);
      head1 = {out_keepalive, out_delta, out_value};
      n_checks++; if (head1 !== ent(1'b0, 0, 0)) begin n_fail++; $display("FAIL overflow head_stable: got %0h, expected %0h", head1, ent(1'b0, 0, 0)); end
      exp_q.push_back(ent(1'b0, 0, 0));
      exp_q.push_back(ent(1'b0, 1, 1));
      exp_q.push_back(ent(1'b0, 1, 0));
      exp_q.push_back(ent(1'b0, 1, 1));
      for (int i = 0; i < 6; i++) step(8'd1, 1'b1);
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL overflow pending: got %0d left, expected 0", exp_q.size()); end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL overflow count_drained: got %0d, expected 0", count); end
      n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL overflow sticky: got %0b, expected 1", overflow); end
   endtask

   task automatic test_back_to_back();
      cur_test = "full_pop_push";
      do_reset();
      exp_q.push_back(ent(1'b0, 0, 0));
      exp_q.push_back(ent(1'b0, 1, 1));
      exp_q.push_back(ent(1'b0, 1, 0));
      exp_q.push_back(ent(1'b0, 1, 1));
      exp_q.push_back(ent(1'b0, 1, 0));
      for (int i = 0; i < 5; i++) step(WIDTH'(i % 2), 1'b0);
      n_checks++; if (count !== 3'd4)       begin n_fail++; $display("FAIL full_pop_push count_before: got %0d, expected 4", count); end
      step(8'd0, 1'b1);
      n_checks++; if (count !== 3'd4)       begin n_fail++; $display("FAIL full_pop_push count_after: got %0d, expected 4", count); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL full_pop_push overflow: got %0b, expected 0", overflow); end
      for (int i = 0; i < 6; i++) step(8'd0, 1'b1);
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL full_pop_push pending: got %0d left, expected 0", exp_q.size()); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL full_pop_push overflow_end: got %0b, expected 0", overflow); end
   endtask

   task automatic test_reset_mid();
      cur_test = "reset_mid";
      do_reset();
      step(8'd10, 1'b0);
      step(8'd20, 1'b0);
      step(8'd30, 1'b0);
      step(8'd30, 1'b0);
      n_checks++; if (count !== 3'd3)       begin n_fail++; $display("FAIL reset_mid count_before: got %0d, expected 3", count); end
      reset = 1'b1;
      step(8'd30, 1'b0);
      reset = 1'b0;
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_mid out_valid: got %0b, expected 0", out_valid); end
      n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL reset_mid count: got %0d, expected 0", count); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_mid overflow: got %0b, expected 0", overflow); end
      exp_q.push_back(ent(1'b0, 0, 77));
      for (int i = 0; i < 5; i++) step(8'd77, 1'b1);
      n_checks++; if (exp_q.size() != 0)    begin n_fail++; $display("FAIL reset_mid pending: got %0d left, expected 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset     = 1'b1;
      sample_in = '0;
      out_ready = 1'b0;
      test_reset();
      test_single_value();
      test_sequence();
      test_keepalive();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
